alu_arbiter: RTL

- Shares one combinational `alu` instance between NUM_REQ requesters (e.g. execute stage, branch-compare unit, CSR unit).
- Round-robin arbitration with valid/ready request and response handshakes.
- Operands and results are registered, and at most one operation is in flight.
- Sits in the execute stage between the requesters and the single `alu`.

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_arbiter_rr.sv | 27 ++
 rtl/alu_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state, ALU opcode encodings and id-width helper for the ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  logic [N-1:0] rot;
  int j;
  int sum;
  // rotate so that bit 0 is the requester at ptr, then take the lowest set bit
  always_comb begin
    rot = N'({req, req} >> ptr);
    any = |rot;
    j = 0;
    for (int i = N - 1; i >= 0; i--) j = rot[i] ? i : j;
    sum = j + int'(ptr);
    idx = ID_W'(sum >= N ? sum - N : sum);
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with registered operands/results
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data1_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data2_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_zero_o,
  output logic                      rsp_sign_o,
  output logic                      busy_o,
  output logic [DATA_W-1:0]         alu_data1_o,
  output logic [DATA_W-1:0]         alu_data2_o,
  output logic [OP_W-1:0]           alu_op_o,
  input  logic [DATA_W-1:0]         alu_data_i,
  input  logic                      alu_zero_i,
  input  logic                      alu_sign_i
);
  localparam int ID_W = id_width(NUM_REQ);
  state_t state, nstate;
  logic [ID_W-1:0] rr_ptr, owner, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic any_gnt, take, done;
  logic [DATA_W-1:0] op1_q, op2_q, res_q;
  logic [OP_W-1:0] op_q;
  logic zero_q, sign_q;
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(req_valid_i),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(any_gnt)
  );
  always_comb begin
    take = state == IDLE && any_gnt && !rst;
    done = state == RESP && rsp_ready_i[owner];
    nstate = take ? EXEC : state == EXEC ? RESP : done ? IDLE : state;
  end
  assign req_ready_o = take ? gnt : '0;
  assign rsp_valid_o = state == RESP ? NUM_REQ'(1) << owner : '0;
  assign busy_o      = state != IDLE;
  assign rsp_data_o  = res_q;
  assign rsp_zero_o  = zero_q;
  assign rsp_sign_o  = sign_q;
  assign alu_data1_o = op1_q;
  assign alu_data2_o = op2_q;
  assign alu_op_o    = op_q;
  // rr_ptr only moves on response completion, so fairness is per finished operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      state <= nstate;
      if (take) begin
        owner <= gnt_idx;
        op1_q <= req_data1_i[int'(gnt_idx)*DATA_W +: DATA_W];
        op2_q <= req_data2_i[int'(gnt_idx)*DATA_W +: DATA_W];
        op_q  <= req_op_i[int'(gnt_idx)*OP_W +: OP_W];
      end
      if (state == EXEC) begin
        res_q  <= alu_data_i;
        zero_q <= alu_zero_i;
        sign_q <= alu_sign_i;
      end
      if (done) rr_ptr <= owner == ID_W'(NUM_REQ - 1) ? '0 : owner + ID_W'(1);
    end
  end
endmodule
